udma_uart_tx_unpack: RTL and testbench
======================================

# udma_uart_tx_unpack

Byte-serialising front end for the uDMA UART transmitter: accepts 32-bit uDMA TX words with a per-word size, buffers them in a small word FIFO, and issues them least-significant byte first as single bytes on the valid/ready byte port that drives the UART TX serialiser. It sits between the uDMA TX channel and the UART TX bit engine, and presents a combined busy flag to the UART register file.

## Interface
- DEPTH, 4, word FIFO depth in entries; power of two, at least 2
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  UART TX enable; 0 pauses the block
- clr_i  in  1  synchronous flush of FIFO and unpacker
- data_i  in  32  uDMA TX word
- datasize_i  in  2  bytes valid in data_i: 00=1, 01=2, 10=4, 11=4
- valid_i  in  1  uDMA word valid
- ready_o  out  1  word accepted when valid_i & ready_o
- tx_data_o  out  8  byte to UART TX engine
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  UART TX engine ready; byte consumed when tx_valid_o & tx_ready_i
- busy_o  out  1  FIFO non-empty or byte transfer pending
- cts_ni  in  1  clear-to-send, active-low; present only with UDMA_UART_TX_CTS_EN

## Operation
- FIFO entry = {data[31:0], nbytes-1[1:0]}; datasize 11 stored as 4 bytes.
- ready_o = cfg_en_i & ~full & ~clr_i. Push on valid_i & ready_o.
- Unpacker FSM, two states:
  - IDLE: if FIFO non-empty and cfg_en_i, pop head into shift register and byte counter cnt = nbytes-1; go SEND.
  - SEND: tx_data_o = shift[7:0]. On byte handshake: if cnt != 0, shift right 8 (zero fill), cnt--; if cnt == 0 and FIFO non-empty, pop next entry in the same cycle (back-to-back, no bubble); else go IDLE.
- tx_valid_o = (state==SEND) & cfg_en_i & cts_ok; cts_ok = 1 without the macro.
- busy_o = ~empty | (state==SEND).
- cfg_en_i = 0: no push, no pop, no byte issue; FSM, shift register and FIFO contents held.
- clr_i = 1: FIFO pointers and count cleared, FSM to IDLE, cnt cleared; has priority over push, pop and handshake in the same cycle.
- Simultaneous push and pop: permitted whenever not full before the edge; full is evaluated on the pre-edge count (no pass-through when full).
- FIFO count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.

## Timing
- Reset: ready_o=0 until first cycle with cfg_en_i=1, tx_valid_o=0, tx_data_o=8'h00, busy_o=0, state IDLE, FIFO empty.
- Latency: word push at edge N into empty FIFO with FSM IDLE -> tx_valid_o high after edge N+1 with byte 0.
- Each subsequent byte of the same word: valid in the cycle after the previous handshake edge; between words likewise (zero idle cycles).
- Outputs registered except ready_o, tx_valid_o, busy_o (decoded from registers and cfg_en_i / synced CTS).

## Configuration
- UDMA_UART_TX_CTS_EN defined: cts_ni port present; two-flop synchroniser, reset value 1 (not clear). cts_ok = ~cts_sync. Deassertion of CTS blocks new byte handshakes only; FIFO keeps accepting words. Added latency 2 cycles from cts_ni edge to tx_valid_o effect.
- Not defined: no cts_ni port, no synchroniser, cts_ok tied 1.

## Structure
- Shared package udma_uart_pkg: datasize encodings, unpacker state enum, FIFO entry struct width constants.
- Sub-module udma_uart_tx_fifo: parameterised synchronous word FIFO (DEPTH, WIDTH=34) with push/pop/clr, full/empty/count. Unpacker FSM and CTS logic stay in the top.

## Test plan
- Push 32'hA1B2C3D4 size 10, tx_ready_i=1 constant -> bytes D4,C3,B2,A1 on four consecutive cycles, tx_valid_o first high 2 cycles after push, busy_o falls after A1.
- Push sizes 00 (32'h000000_55), 01 (32'h0000_7788), 11 (32'h11223344) back-to-back -> byte stream 55,88,77,44,33,22,11, no gaps.
- Push DEPTH+1 words with tx_ready_i=0 -> ready_o low after DEPTH accepted words (with none popped) then DEPTH-1 after first pop; no word lost or duplicated.
- Mid-word clr_i pulse after byte 1 of 32'hDEADBEEF -> tx_valid_o low next cycle, busy_o 0, next pushed word 32'h000000_42 size 00 emits 42 only.
- cfg_en_i dropped for 10 cycles mid-word -> tx_valid_o and ready_o low, resume emits remaining bytes in order.
- With UDMA_UART_TX_CTS_EN: cts_ni=1 holds tx_valid_o low while FIFO fills; cts_ni->0 yields tx_valid_o high 2-3 cycles later.

Source files
------------

// File: rtl/udma_uart_pkg.sv
// Shared definitions for the uDMA UART TX byte unpacker: datasize encodings,
// unpacker state codes and the word FIFO entry layout.
package udma_uart_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NB_W    = 2;
    localparam int unsigned ENTRY_W = WORD_W + NB_W;

    typedef enum logic [1:0] {
        DS_1B     = 2'b00,
        DS_2B     = 2'b01,
        DS_4B     = 2'b10,
        DS_4B_ALT = 2'b11
    } datasize_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [NB_W-1:0]   nbm1;
    } tx_entry_t;

    // Byte count minus one; the reserved 11 encoding is treated as a full word.
    function automatic logic [NB_W-1:0] datasize_to_nbm1(input logic [1:0] ds);
        case (datasize_e'(ds))
            DS_1B:     return 2'd0;
            DS_2B:     return 2'd1;
            DS_4B:     return 2'd3;
            DS_4B_ALT: return 2'd3;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/udma_uart_tx_unpack_if.sv
// Word-in / byte-out handshake bundle of the uDMA UART TX unpacker.
interface udma_uart_tx_unpack_if;
    logic [31:0] data;
    logic [1:0]  datasize;
    logic        valid;
    logic        ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  data, datasize, valid, tx_ready,
        output ready, tx_data, tx_valid
    );

    modport master (
        output data, datasize, valid, tx_ready,
        input  ready, tx_data, tx_valid
    );
endinterface

// File: rtl/udma_uart_tx_fifo.sv
// Synchronous word FIFO with flush; head entry is visible combinationally on dout_o.
module udma_uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem[rd_ptr_q];

    // Full and empty come from the pre-edge count, so a push into a full FIFO
    // is dropped even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/udma_uart_tx_unpack.sv
// uDMA UART TX front end: buffers 32-bit words and issues them LSB byte first.
// Optional UDMA_UART_TX_CTS_EN adds a synchronised active-low cts_ni gate.
module udma_uart_tx_unpack
    import udma_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cfg_en_i,
    input  logic                     clr_i,
`ifdef UDMA_UART_TX_CTS_EN
    input  logic                     cts_ni,
`endif
    udma_uart_tx_unpack_if.slave     bus,
    output logic                     busy_o
);
    logic [0:0]            state_q;
    logic [WORD_W-1:0]     shift_q;
    logic [NB_W-1:0]       cnt_q;

    tx_entry_t             push_entry;
    tx_entry_t             head_entry;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    logic                  sending;
    logic                  cts_ok;
    logic                  tx_valid;
    logic                  handshake;
    logic                  last_byte;
    logic                  push;
    logic                  pop;

`ifdef UDMA_UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    // Resets to "not clear" so nothing is sent until CTS is seen asserted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_ni};
        end
    end

    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign sending   = (state_q == ST_SEND);
    assign tx_valid  = sending & cfg_en_i & cts_ok;
    assign handshake = tx_valid & bus.tx_ready;
    assign last_byte = (cnt_q == '0);

    assign bus.ready    = cfg_en_i & ~fifo_full & ~clr_i;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = shift_q[7:0];
    assign busy_o       = (fifo_count != '0) | sending;

    assign push = bus.valid & bus.ready;

    // Reload either from IDLE or on the final byte's handshake, so words
    // follow each other without an idle cycle.
    assign pop = ~clr_i & cfg_en_i & ~fifo_empty & (~sending | (handshake & last_byte));

    assign push_entry.data = bus.data;
    assign push_entry.nbm1 = datasize_to_nbm1(bus.datasize);
    assign head_entry      = tx_entry_t'(fifo_dout);

    udma_uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) i_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (clr_i),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (pop) begin
            state_q <= ST_SEND;
            shift_q <= head_entry.data;
            cnt_q   <= head_entry.nbm1;
        end else if (handshake) begin
            if (!last_byte) begin
                shift_q <= {8'h00, shift_q[WORD_W-1:8]};
                cnt_q   <= cnt_q - 1'b1;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_udma_uart_tx_unpack.sv
// Randomised and directed bench for udma_uart_tx_unpack with a queue-based byte model.
module tb_udma_uart_tx_unpack;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cfg_en = 1'b0;
    logic clr = 1'b0;
    logic busy;
`ifdef UDMA_UART_TX_CTS_EN
    logic cts_n = 1'b0;
`endif

    udma_uart_tx_unpack_if bus_if();

    udma_uart_tx_unpack #(.DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .cfg_en_i (cfg_en),
        .clr_i    (clr),
`ifdef UDMA_UART_TX_CTS_EN
        .cts_ni   (cts_n),
`endif
        .bus      (bus_if),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] d;
        int          n;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  cur[$];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    bit          model_on = 0;
    int          m_acc = 0;

    function automatic int nbytes(input logic [1:0] ds);
        return (ds == 2'b00) ? 1 : (ds == 2'b01) ? 2 : 4;
    endfunction

    // Model: FIFO of words plus the byte list of the word being sent.
    always @(negedge clk) begin
        bit         sending;
        bit         e_valid;
        bit         e_ready;
        bit         e_busy;
        int         pre_n;
        ent_t       e;
        logic [7:0] dropped;
        if (model_on) begin
            sending = (cur.size() > 0);
            e_valid = sending && cfg_en;
            e_ready = cfg_en && (mq.size() < DEPTH) && !clr;
            e_busy  = (mq.size() > 0) || sending;
            chk("tx_valid", {31'b0, bus_if.tx_valid}, {31'b0, e_valid});
            chk("ready", {31'b0, bus_if.ready}, {31'b0, e_ready});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            if (e_valid) chk("tx_data", {24'b0, bus_if.tx_data}, {24'b0, cur[0]});
            if (bus_if.tx_valid && bus_if.tx_ready) got.push_back(bus_if.tx_data);

            if (clr) begin
                mq.delete();
                cur.delete();
            end else if (cfg_en) begin
                pre_n = mq.size();
                if (sending && bus_if.tx_ready) dropped = cur.pop_front();
                if (cur.size() == 0 && pre_n > 0) begin
                    e = mq.pop_front();
                    for (int i = 0; i < e.n; i++) cur.push_back(e.d[8*i +: 8]);
                end
                if (bus_if.valid && pre_n < DEPTH) begin
                    e.d = bus_if.data;
                    e.n = nbytes(bus_if.datasize);
                    mq.push_back(e);
                    m_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [1:0] ds);
        bus_if.valid    = 1'b1;
        bus_if.data     = d;
        bus_if.datasize = ds;
        tick();
        bus_if.valid    = 1'b0;
    endtask

    task automatic check_stream(input string nm);
        chk({nm, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), {24'b0, got[i]}, {24'b0, exp_q[i]});
    endtask

    initial begin
        bus_if.valid    = 1'b0;
        bus_if.data     = '0;
        bus_if.datasize = '0;
        bus_if.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus_if.ready}, 32'd0);
        chk("rst_tx_valid", {31'b0, bus_if.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, bus_if.tx_data}, 32'h00);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rstn = 1'b1;
        tick();
        cfg_en = 1'b1;
        model_on = 1;
        repeat (4) tick();

        // Single full word, continuous ready
        got.delete();
        bus_if.tx_ready = 1'b1;
        push_word(32'hA1B2C3D4, 2'b10);
        @(negedge clk);
        chk("t1_lat_first", {31'b0, bus_if.tx_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_valid", {31'b0, bus_if.tx_valid}, 32'd1);
        chk("t1_lat_data", {24'b0, bus_if.tx_data}, 32'hD4);
        repeat (6) tick();
        exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        check_stream("t1");
        chk("t1_busy_end", {31'b0, busy}, 32'd0);

        // Mixed sizes back to back
        got.delete();
        push_word(32'h00000055, 2'b00);
        push_word(32'h00007788, 2'b01);
        push_word(32'h11223344, 2'b11);
        repeat (10) tick();
        exp_q = '{8'h55, 8'h88, 8'h77, 8'h44, 8'h33, 8'h22, 8'h11};
        check_stream("t2");

        // Fill with the byte engine stalled
        got.delete();
        m_acc = 0;
        bus_if.tx_ready = 1'b0;
        bus_if.datasize = 2'b10;
        bus_if.valid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus_if.data = 32'h10203040 + i;
            tick();
        end
        bus_if.valid = 1'b0;
        chk("t3_accepted", m_acc, DEPTH + 1);
        bus_if.tx_ready = 1'b1;
        repeat (4 * (DEPTH + 1) + 4) tick();
        exp_q.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            logic [31:0] w;
            w = 32'h10203040 + i;
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
        check_stream("t3");

        // Flush mid-word
        got.delete();
        push_word(32'hDEADBEEF, 2'b10);
        tick();
        tick();
        bus_if.tx_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("t4_valid_after_clr", {31'b0, bus_if.tx_valid}, 32'd0);
        chk("t4_busy_after_clr", {31'b0, busy}, 32'd0);
        bus_if.tx_ready = 1'b1;
        push_word(32'h00000042, 2'b00);
        repeat (5) tick();
        exp_q = '{8'hEF, 8'h42};
        check_stream("t4");

        // Enable dropped mid-word
        got.delete();
        push_word(32'hCAFEF00D, 2'b10);
        tick();
        tick();
        cfg_en = 1'b0;
        bus_if.valid = 1'b1;
        bus_if.data = 32'h99999999;
        repeat (10) tick();
        chk("t5_ready_off", {31'b0, bus_if.ready}, 32'd0);
        chk("t5_valid_off", {31'b0, bus_if.tx_valid}, 32'd0);
        bus_if.valid = 1'b0;
        cfg_en = 1'b1;
        repeat (6) tick();
        exp_q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        check_stream("t5");

        // Random traffic
        repeat (800) begin
            bus_if.valid    = $urandom_range(0, 1) != 0;
            bus_if.data     = $urandom;
            bus_if.datasize = 2'($urandom_range(0, 3));
            bus_if.tx_ready = $urandom_range(0, 3) != 0;
            cfg_en          = $urandom_range(0, 15) != 0;
            clr             = $urandom_range(0, 63) == 0;
            tick();
        end
        bus_if.valid = 1'b0;
        clr = 1'b0;
        cfg_en = 1'b1;
        bus_if.tx_ready = 1'b1;
        repeat (40) tick();
        chk("drain_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
